// File: rtl/spi_slave_resp.sv
// SPI slave/responder: oversampled ss/sck/mosi, word-framed full duplex, all four SPI modes.
// Optional build macro SPI_SLAVE_LSB_FIRST_EN switches both directions to LSB first.
module spi_slave_resp #(
  parameter int                DATA_W  = 8,
  parameter bit                CPOL    = 1'b0,
  parameter bit                CPHA    = 1'b0,
  parameter logic [DATA_W-1:0] TX_IDLE = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ss,
  input  logic              sck,
  input  logic              mosi,
  output logic              miso_drv,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              underrun,
  output logic              abort,
  output logic              busy
);

  localparam int              CW   = $clog2(DATA_W);
  localparam logic [CW-1:0]   LAST = CW'(DATA_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT} state_t;

  state_t              r_state, w_state_nxt;
  logic [2:0]          r_ss_sr, r_sck_sr;
  logic [1:0]          r_mosi_sr;
  logic [CW-1:0]       r_bit_cnt;
  logic [DATA_W-1:0]   r_rx_shift, r_rx_data;
  logic [DATA_W-1:0]   r_tx_shift, r_tx_next, r_hold;
  logic                r_hold_full, r_pend, r_unr_pend;
  logic                r_rx_valid, r_underrun, r_abort;

  logic                w_ss_s, w_ss_d, w_sck_s, w_sck_d, w_mosi_s;
  logic                w_ss_fall, w_lead, w_trail, w_sample, w_shift;
  logic                w_in_shift, w_active;
  logic                w_smp, w_last, w_shf, w_leave, w_abort, w_take, w_load_hold;
  logic [CW-1:0]       w_cnt_after;
  logic [DATA_W-1:0]   w_word, w_rx_next, w_tx_shifted;
  logic                w_tx_out;

  // Two-flop synchronisers plus a third copy of ss/sck for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ss_sr   <= '1;
      r_sck_sr  <= {3{CPOL}};
      r_mosi_sr <= '0;
    end else begin
      r_ss_sr   <= {r_ss_sr[1:0], ss};
      r_sck_sr  <= {r_sck_sr[1:0], sck};
      r_mosi_sr <= {r_mosi_sr[0], mosi};
    end
  end

  assign w_ss_s    = r_ss_sr[1];
  assign w_ss_d    = r_ss_sr[2];
  assign w_sck_s   = r_sck_sr[1];
  assign w_sck_d   = r_sck_sr[2];
  assign w_mosi_s  = r_mosi_sr[1];
  assign w_ss_fall = !w_ss_s && w_ss_d;
  assign w_lead    = (w_sck_s != CPOL) && (w_sck_d == CPOL);
  assign w_trail   = (w_sck_s == CPOL) && (w_sck_d != CPOL);
  assign w_sample  = CPHA ? w_trail : w_lead;
  assign w_shift   = CPHA ? w_lead  : w_trail;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_shift  = 1'b0;
    w_active    = 1'b0;
    case (r_state)
      S_IDLE:  if (w_ss_fall) w_state_nxt = S_LOAD;
      S_LOAD:  begin
        w_active    = 1'b1;
        w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        w_active   = 1'b1;
        w_in_shift = 1'b1;
        if (w_ss_s) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

`ifdef SPI_SLAVE_LSB_FIRST_EN
  assign w_rx_next    = {w_mosi_s, r_rx_shift[DATA_W-1:1]};
  assign w_tx_shifted = {1'b0, r_tx_shift[DATA_W-1:1]};
  assign w_tx_out     = r_tx_shift[0];
`else
  assign w_rx_next    = {r_rx_shift[DATA_W-2:0], w_mosi_s};
  assign w_tx_shifted = {r_tx_shift[DATA_W-2:0], 1'b0};
  assign w_tx_out     = r_tx_shift[DATA_W-1];
`endif

  assign w_smp       = w_in_shift && w_sample;
  assign w_last      = w_smp && (r_bit_cnt == LAST);
  assign w_shf       = w_in_shift && w_shift;
  assign w_leave     = w_in_shift && w_ss_s;
  assign w_cnt_after = w_last ? '0 : (w_smp ? r_bit_cnt + 1'b1 : r_bit_cnt);
  // A word finishing on the same clk that ss goes away is complete, not aborted.
  assign w_abort     = w_leave && (w_cnt_after != '0);
  assign w_take      = ((r_state == S_LOAD) || w_last) && r_hold_full;
  assign w_load_hold = tx_valid && !r_hold_full;
  assign w_word      = r_hold_full ? r_hold : TX_IDLE;

  // Holding register: the reload sees the old contents; a same-clk tx_valid only
  // lands when holding was already empty, so the two never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else if (w_load_hold) begin
      r_hold      <= tx_data;
      r_hold_full <= 1'b1;
    end else if (w_take) begin
      r_hold_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt  <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_abort    <= 1'b0;
    end else begin
      r_bit_cnt  <= (w_in_shift && !w_leave) ? w_cnt_after : '0;
      r_rx_valid <= w_last;
      r_abort    <= w_abort;
      if (w_smp)  r_rx_shift <= w_rx_next;
      if (w_last) r_rx_data  <= w_rx_next;
    end
  end

  // The next word is parked in r_tx_next at the final sample and only lands in the
  // shifter on the following shift edge, so the current last bit stays valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_shift <= '0;
      r_tx_next  <= '0;
      r_pend     <= 1'b0;
    end else if (r_state == S_IDLE) begin
      r_pend     <= 1'b0;
    end else if (r_state == S_LOAD) begin
      r_tx_shift <= w_word;
      r_tx_next  <= w_word;
      r_pend     <= CPHA;
    end else if (w_last) begin
      r_tx_next  <= w_word;
      r_pend     <= 1'b1;
    end else if (w_shf) begin
      r_pend     <= 1'b0;
      r_tx_shift <= r_pend ? r_tx_next : w_tx_shifted;
    end
  end

  // A reload from an empty holding register only counts as an underrun once the
  // master actually clocks the next word; a frame ending on a word boundary is clean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_unr_pend <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= ((r_state == S_LOAD) && !r_hold_full) ||
                    (w_smp && (r_bit_cnt == '0) && r_unr_pend);
      if (!w_in_shift)                        r_unr_pend <= 1'b0;
      else if (w_last && !r_hold_full)        r_unr_pend <= 1'b1;
      else if (w_smp && (r_bit_cnt == '0))    r_unr_pend <= 1'b0;
    end
  end

  assign miso_drv = w_active && !w_ss_s && !ss && w_tx_out;
  assign tx_ready = !r_hold_full;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign underrun = r_underrun;
  assign abort    = r_abort;
  assign busy     = !w_ss_s;

endmodule
